// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       parity_err;
        logic       frame_err;
    } rx_entry_t;

    // Clock cycles per oversample tick (integer divide, truncating)
    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - receive-byte valid/ready handshake toward the host
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_parity_err,
        output rx_frame_err,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word fall-through buffer of received bytes and flags
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  rx_entry_t push_entry,
    input  logic      pop,
    output rx_entry_t head,
    output logic      valid,
    output logic      overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);

    rx_entry_t      mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           empty;
    logic           full;
    logic           pop_ok;
    logic           push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push_ok = push && (!full || pop_ok);
    assign overrun = push && full && !pop_ok;

    assign valid   = !empty;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    // Read/write pointers with wrap bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with parity/stop checking and buffering
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_EN   = 1,
    parameter int PARITY_ODD  = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd,
    uart_rx_core_if.master   rx_if,
    output logic             overrun,
    output logic             busy
);

    localparam int   DIV     = baud_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int   DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int   OW      = $clog2(OVERSAMPLE);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    logic [1:0]     sync_q;
    logic           rxd_s;
    logic           rxd_prev;
    rx_state_e      state;
    rx_state_e      next_state;
    logic [DW-1:0]  div_cnt;
    logic [OW-1:0]  os_cnt;
    logic           tick;
    logic           sample;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           par_err_q;
    logic           shift_en;
    logic           par_en;
    logic           stop_en;
    logic           push_q;
    rx_entry_t      push_entry_q;
    rx_entry_t      head;
    logic           head_valid;

    assign rxd_s = sync_q[1];

    // Two-flop synchronizer plus one delayed copy for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            rxd_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[0], rxd};
            rxd_prev <= rxd_s;
        end
    end

    // Start bit samples at half a bit, later bits every full bit (bit centres)
    assign tick   = (div_cnt == DW'(DIV - 1));
    assign sample = tick && ((state == START) ? (os_cnt == OW'(OVERSAMPLE/2 - 1))
                                              : (os_cnt == OW'(OVERSAMPLE - 1)));

    // Tick and oversample counters; held clear in IDLE so START begins phase-aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (state == IDLE) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= sample ? '0 : os_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // FSM next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (rxd_prev && !rxd_s) next_state = START;
            START:  if (sample) next_state = rxd_s ? IDLE : DATA;
            DATA:   if (sample && bit_cnt == 3'd7) next_state = PAR_EN ? PARITY : STOP;
            PARITY: if (sample) next_state = STOP;
            STOP:   if (sample) next_state = rxd_s ? IDLE : BREAK;
            BREAK:  if (rxd_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: status and per-state sample strobes
    always_comb begin
        busy     = (state != IDLE);
        shift_en = (state == DATA) && sample;
        par_en   = (state == PARITY) && sample;
        stop_en  = (state == STOP) && sample;
    end

    // Shift register, bit counter and parity check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_err_q <= 1'b0;
        end else if (state == IDLE) begin
            bit_cnt   <= '0;
            par_err_q <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_reg <= {rxd_s, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (par_en) begin
                par_err_q <= (^shift_reg) ^ rxd_s ^ PAR_ODD;
            end
        end
    end

    // Register the completed frame; written into the FIFO on the next clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            push_q <= stop_en;
            if (stop_en) begin
                push_entry_q.data       <= shift_reg;
                push_entry_q.parity_err <= par_err_q;
                push_entry_q.frame_err  <= ~rxd_s;
            end
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_q),
        .push_entry (push_entry_q),
        .pop        (rx_if.rx_ready),
        .head       (head),
        .valid      (head_valid),
        .overrun    (overrun)
    );

    assign rx_if.rx_data       = head.data;
    assign rx_if.rx_parity_err = head.parity_err;
    assign rx_if.rx_frame_err  = head.frame_err;
    assign rx_if.rx_valid      = head_valid;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int BIT      = 16 * 27;
    localparam int VALID_AT = 4540;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;
    logic overrun;
    logic busy;
    int   cyc   = 0;

    uart_rx_core_if rx_if();

    uart_rx_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rxd     (rxd),
        .rx_if   (rx_if),
        .overrun (overrun),
        .busy    (busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int        tests = 0;
    int        fails = 0;
    rx_entry_t exp_q[$];
    int        ovr_cnt = 0;
    int        valid_hi_cnt = 0;
    int        valid_rise_cyc = 0;
    int        frame_start = 0;
    vec_t      vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b);
        rxd = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb, input int low_after);
        @(posedge clk);
        #1;
        frame_start = cyc;
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(d[i]);
        drive(pb);
        drive(sb);
        for (int i = 0; i < low_after; i++) drive(1'b0);
        rxd = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("busy_clears", busy, 0);
    endtask

    function automatic rx_entry_t mk(input logic [7:0] d, input logic pe, input logic fe);
        rx_entry_t e;
        e.data = d;
        e.parity_err = pe;
        e.frame_err = fe;
        return e;
    endfunction

    initial begin
        #(95000 * 20);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1};

        rx_if.rx_ready = 1'b1;

        fork
            begin : monitor
                logic      prev_valid = 1'b0;
                logic      hold_pending = 1'b0;
                rx_entry_t held = '0;
                rx_entry_t cur;
                rx_entry_t e;
                forever begin
                    @(negedge clk);
                    cur = mk(rx_if.rx_data, rx_if.rx_parity_err, rx_if.rx_frame_err);
                    if (overrun) ovr_cnt++;
                    if (hold_pending && rst_n) begin
                        check("hold_valid", rx_if.rx_valid, 1);
                        check("hold_entry", cur, held);
                    end
                    hold_pending = rx_if.rx_valid && !rx_if.rx_ready;
                    held = cur;
                    if (rx_if.rx_valid) begin
                        valid_hi_cnt++;
                        if (!prev_valid) valid_rise_cyc = cyc;
                    end
                    prev_valid = rx_if.rx_valid;
                    if (rx_if.rx_valid && rx_if.rx_ready) begin
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL unexpected_entry: got 0x%0h, want no entry", cur);
                        end else begin
                            e = exp_q.pop_front();
                            if (cur !== e) begin
                                fails++;
                                $display("FAIL entry: got 0x%0h, want 0x%0h", cur, e);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", rx_if.rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_entry", {rx_if.rx_data, rx_if.rx_parity_err, rx_if.rx_frame_err}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Table-driven single frames with exact output latency
        for (int v = 0; v < 4; v++) begin
            valid_hi_cnt = 0;
            exp_q.push_back(mk(vecs[v].data, vecs[v].exp_pe, vecs[v].exp_fe));
            send_frame(vecs[v].data, vecs[v].pbit, vecs[v].sbit, 0);
            wait_idle(50);
            repeat (5) @(negedge clk);
            check($sformatf("valid_latency_%0d", v), valid_rise_cyc - frame_start, VALID_AT);
            check($sformatf("valid_pulse_%0d", v), valid_hi_cnt, 1);
            check($sformatf("sb_empty_%0d", v), exp_q.size(), 0);
        end

        // Stop bit 0 then line held low: one entry, busy until line returns high
        valid_hi_cnt = 0;
        exp_q.push_back(mk(8'h7E, 1'b0, 1'b1));
        send_frame(8'h7E, 1'b0, 1'b0, 3);
        check("break_busy", busy, 1);
        wait_idle(20);
        repeat (BIT) @(negedge clk);
        check("break_one_entry", valid_hi_cnt, 1);
        check("break_sb_empty", exp_q.size(), 0);

        // Glitch shorter than half a bit: false start
        valid_hi_cnt = 0;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (100) @(posedge clk);
        #1 rxd = 1'b1;
        @(negedge clk);
        check("glitch_busy", busy, 1);
        wait_idle(400);
        repeat (20) @(negedge clk);
        check("glitch_no_entry", valid_hi_cnt, 0);
        check("glitch_flags", {rx_if.rx_parity_err, rx_if.rx_frame_err}, 0);

        // Overrun: consumer stalled, five frames back to back
        rx_if.rx_ready = 1'b0;
        ovr_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] d;
            d = 8'(i);
            if (i <= 4) exp_q.push_back(mk(d, 1'b0, 1'b0));
            send_frame(d, ^d, 1'b1, 0);
            if (i == 4) check("no_overrun_before_5th", ovr_cnt, 0);
        end
        repeat (10) @(negedge clk);
        check("overrun_once", ovr_cnt, 1);
        check("head_oldest", rx_if.rx_data, 8'h01);
        @(posedge clk);
        #1 rx_if.rx_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("drain_sb_empty", exp_q.size(), 0);
        check("drain_valid", rx_if.rx_valid, 0);

        // Reset during data bit 3, then a clean frame
        valid_hi_cnt = 0;
        @(posedge clk);
        #1;
        drive(1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0);
        rxd = 1'b0;
        repeat (BIT / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_valid", rx_if.rx_valid, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_entry", {rx_if.rx_data, rx_if.rx_parity_err, rx_if.rx_frame_err}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("midrst_no_entry", valid_hi_cnt, 0);
        exp_q.push_back(mk(8'h3C, 1'b0, 1'b0));
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        wait_idle(50);
        repeat (5) @(negedge clk);
        check("post_rst_sb_empty", exp_q.size(), 0);
        check("post_rst_pulse", valid_hi_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
